vital_threshold_scheduler: RTL and testbench

Time-multiplexes one shared 8-bit magnitude comparator across four vital-sign sample channels: heart rate, temperature, systolic pressure and SpO2. Each accepted sample is checked against its channel's programmable low and high thresholds in two successive comparator passes, and a result code is reported. A per-channel hysteresis counter raises and clears the alarm outputs. The block sits between the sensor front-ends and the alarm/display logic of the monitoring system.

---
 rtl/vital_threshold_scheduler.sv | 152 +++++++++++++++
 tb/tb_vital_threshold_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vital_threshold_scheduler.sv
// Four-channel vital-sign threshold checker sharing one cascadable 8-bit magnitude
// comparator, with round-robin sample intake and per-channel alarm hysteresis.

module vital_threshold_cmp8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       lt_in,
    input  logic       eq_in,
    input  logic       gt_in,
    output logic       lt,
    output logic       eq,
    output logic       gt
);
    always_comb begin
        lt = (a < b) | ((a == b) & lt_in);
        eq = (a == b) & eq_in;
        gt = (a > b) | ((a == b) & gt_in);
    end
endmodule

module vital_threshold_scheduler #(
    parameter int ALARM_CNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  smp_valid,
    input  logic [31:0] smp_data,
    output logic [3:0]  smp_ready,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_ch,
    input  logic        cfg_sel,
    input  logic [7:0]  cfg_data,
    output logic        res_valid,
    output logic [1:0]  res_ch,
    output logic [1:0]  res_code,
    output logic [3:0]  alarm,
    output logic        busy
);
    localparam logic [3:0] ALARM_TH = 4'(ALARM_CNT);

    typedef enum logic [1:0] {IDLE, CMP_LO, CMP_HI, RESULT} state_t;

    state_t      state, state_next;
    logic [1:0]  rr_ptr;
    logic [1:0]  grant;
    logic        grant_vld;
    logic        accept;
    logic [7:0]  smp_q;
    logic [1:0]  ch_q;
    logic        below;
    logic [7:0]  lo_thr [4];
    logic [7:0]  hi_thr [4];
    logic [2:0]  cnt [4];
    logic [7:0]  cmp_b;
    logic        cmp_lt, cmp_eq, cmp_gt;
    logic        above_now;
    logic        below_now;
    logic [1:0]  code_now;
    logic [3:0]  cnt_inc;

    // Search starts one past the last grant so every channel gets a turn.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!grant_vld && smp_valid[rr_ptr + 2'(k)]) begin
                grant     = rr_ptr + 2'(k);
                grant_vld = 1'b1;
            end
        end
    end

    assign accept    = (state == IDLE) && grant_vld && !rst;
    assign smp_ready = accept ? (4'b0001 << grant) : 4'b0000;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CMP_LO;
            CMP_LO:  state_next = CMP_HI;
            CMP_HI:  state_next = RESULT;
            RESULT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cmp_b = (state == CMP_HI) ? hi_thr[ch_q] : lo_thr[ch_q];

    vital_threshold_cmp8 u_cmp (
        .a     (smp_q),
        .b     (cmp_b),
        .lt_in (1'b0),
        .eq_in (1'b1),
        .gt_in (1'b0),
        .lt    (cmp_lt),
        .eq    (cmp_eq),
        .gt    (cmp_gt)
    );

    // Flags are mutually exclusive; masking with eq keeps equality strictly in range.
    assign below_now = cmp_lt & ~cmp_eq;
    assign above_now = cmp_gt & ~cmp_eq;
    assign code_now  = {above_now, below};
    assign cnt_inc   = {1'b0, cnt[ch_q]} + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 2'd3;
            smp_q     <= '0;
            ch_q      <= '0;
            below     <= 1'b0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_code  <= '0;
            alarm     <= '0;
            for (int i = 0; i < 4; i++) begin
                lo_thr[i] <= 8'h00;
                hi_thr[i] <= 8'hFF;
                cnt[i]    <= '0;
            end
        end else begin
            state     <= state_next;
            res_valid <= 1'b0;
            if (cfg_we) begin
                if (cfg_sel) hi_thr[cfg_ch] <= cfg_data;
                else         lo_thr[cfg_ch] <= cfg_data;
            end
            if (accept) begin
                smp_q  <= smp_data[{grant, 3'b000} +: 8];
                ch_q   <= grant;
                rr_ptr <= grant;
            end
            if (state == CMP_LO) below <= below_now;
            if (state == CMP_HI) begin
                res_valid <= 1'b1;
                res_ch    <= ch_q;
                res_code  <= code_now;
                // A sample agreeing with the current alarm level restarts the count.
                if ((|code_now) == alarm[ch_q]) begin
                    cnt[ch_q] <= '0;
                end else if (cnt_inc == ALARM_TH) begin
                    alarm[ch_q] <= ~alarm[ch_q];
                    cnt[ch_q]   <= '0;
                end else begin
                    cnt[ch_q] <= cnt_inc[2:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_vital_threshold_scheduler.sv
// Directed bench for vital_threshold_scheduler: thresholds, result codes, hysteresis,
// round-robin order, reset and mid-operation threshold writes.

module tb_vital_threshold_scheduler;
    logic        clk;
    logic        rst;
    logic [3:0]  smp_valid;
    logic [31:0] smp_data;
    logic [3:0]  smp_ready;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic        cfg_sel;
    logic [7:0]  cfg_data;
    logic        res_valid;
    logic [1:0]  res_ch;
    logic [1:0]  res_code;
    logic [3:0]  alarm;
    logic        busy;

    int total = 0;
    int bad   = 0;

    vital_threshold_scheduler #(.ALARM_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .smp_ready (smp_ready),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_code  (res_code),
        .alarm     (alarm),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input logic sel, input logic [7:0] data);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_sel  = sel;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Runs one sample from its ready strobe through to the idle cycle after RESULT.
    task automatic run_sample(input int ch, input logic [7:0] data, input logic [1:0] exp_code,
                              input logic [3:0] exp_alarm, input bit mid_wr, input logic [7:0] mid_hi);
        int waited;
        waited = 0;
        smp_data[ch*8 +: 8] = data;
        smp_valid[ch] = 1'b1;
        #1;
        while (smp_ready[ch] !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        check("ready", smp_ready, 32'(4'b0001 << ch));
        tick();
        smp_valid[ch] = 1'b0;
        check("t1_res_valid", res_valid, 0);
        check("t1_busy", busy, 1);
        if (mid_wr) begin
            cfg_we   = 1'b1;
            cfg_ch   = 2'(ch);
            cfg_sel  = 1'b1;
            cfg_data = mid_hi;
        end
        tick();
        cfg_we = 1'b0;
        check("t2_res_valid", res_valid, 0);
        tick();
        check("t3_res_valid", res_valid, 1);
        check("t3_res_ch", res_ch, ch);
        check("t3_res_code", res_code, exp_code);
        check("t3_alarm", alarm, exp_alarm);
        check("t3_busy", busy, 1);
        tick();
        check("t4_res_valid", res_valid, 0);
        check("t4_busy", busy, 0);
    endtask

    localparam logic [1:0] C_IN = 2'b00, C_LO = 2'b01, C_HI = 2'b10, C_BOTH = 2'b11;

    logic [7:0] hyst_data [9] = '{8'd40, 8'd40, 8'd70, 8'd40, 8'd40, 8'd40, 8'd70, 8'd70, 8'd70};
    logic [1:0] hyst_code [9] = '{C_LO, C_LO, C_IN, C_LO, C_LO, C_LO, C_IN, C_IN, C_IN};
    logic       hyst_alarm[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int         arb_order [8] = '{0, 1, 2, 3, 0, 2, 3, 0};

    initial begin
        rst = 1'b1;
        smp_valid = 4'b0001;
        smp_data = '0;
        cfg_we = 1'b0;
        cfg_ch = '0;
        cfg_sel = 1'b0;
        cfg_data = '0;
        tick();
        tick();
        check("rst_ready_gated", smp_ready, 0);
        smp_valid = 4'b0000;
        rst = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_ch", res_ch, 0);
        check("rst_res_code", res_code, 0);
        check("rst_alarm", alarm, 0);
        check("rst_ready", smp_ready, 0);

        // Default thresholds cover the full range
        run_sample(0, 8'h00, C_IN, 4'b0000, 0, 8'h00);
        run_sample(3, 8'hFF, C_IN, 4'b0000, 0, 8'h00);

        cfg_write(1, 1'b0, 8'd60);
        cfg_write(1, 1'b1, 8'd100);
        run_sample(1, 8'd60,  C_IN, 4'b0000, 0, 8'h00);
        run_sample(1, 8'd100, C_IN, 4'b0000, 0, 8'h00);
        run_sample(1, 8'd59,  C_LO, 4'b0000, 0, 8'h00);
        run_sample(1, 8'd101, C_HI, 4'b0000, 0, 8'h00);

        cfg_write(0, 1'b0, 8'd50);
        for (int i = 0; i < 9; i++)
            run_sample(0, hyst_data[i], hyst_code[i], {3'b000, hyst_alarm[i]}, 0, 8'h00);

        cfg_write(2, 1'b0, 8'd80);
        cfg_write(2, 1'b1, 8'd40);
        run_sample(2, 8'd60, C_BOTH, 4'b0000, 0, 8'h00);
        run_sample(2, 8'd60, C_BOTH, 4'b0000, 0, 8'h00);
        run_sample(2, 8'd60, C_BOTH, 4'b0100, 0, 8'h00);

        // Reset during CMP_HI discards the sample
        smp_data[23:16] = 8'd60;
        smp_valid[2] = 1'b1;
        #1;
        check("mid_rst_ready", smp_ready, 4'b0100);
        tick();
        smp_valid[2] = 1'b0;
        tick();
        check("mid_rst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready_low", smp_ready, 0);
        tick();
        rst = 1'b0;
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_alarm", alarm, 0);
        tick();
        check("mid_rst_res_valid_late", res_valid, 0);

        // Round robin: all valid, then ch1 dropped
        smp_data = {8'd50, 8'd40, 8'd30, 8'd20};
        for (int c = 0; c < 32; c++) begin
            smp_valid = (c < 16) ? 4'b1111 : 4'b1101;
            #1;
            if (c % 4 == 0) check("arb_grant", smp_ready, 32'(4'b0001 << arb_order[c / 4]));
            else            check("arb_gap", smp_ready, 0);
            tick();
        end
        smp_valid = 4'b0000;

        // High threshold rewritten while the low pass is in flight
        run_sample(0, 8'd20, C_HI, 4'b0000, 1, 8'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
